// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: data-register writes feed an 8-entry FIFO,
// a status/control register sits at BaseAddr+1, and a drain-complete interrupt is raised.
module bus_uart_tx #(
  parameter logic [7:0]  BaseAddr     = 8'hD0,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_AW      = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  inout  wire  [7:0] BUS_DATA,
  input  logic [7:0] BUS_ADDR,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK,
  output logic       UART_TX
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam int unsigned CntW  = FIFO_AW + 1;
  localparam int unsigned BaudW = 12;

  localparam logic [7:0]       CtrlAddr = 8'(BaseAddr + 8'd1);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  typedef struct packed {
    logic       full;
    logic       empty;
    logic       busy;
    logic       overflow;
    logic [3:0] count;
  } status_t;

  // Bus decode
  logic wr_data_c;
  logic wr_ctrl_c;
  logic rd_stat_c;

  assign wr_data_c = BUS_WE && (BUS_ADDR == BaseAddr);
  assign wr_ctrl_c = BUS_WE && (BUS_ADDR == CtrlAddr);
  assign rd_stat_c = !BUS_WE && (BUS_ADDR == CtrlAddr);

  // FIFO storage and bookkeeping
  logic [7:0]         mem [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [CntW-1:0]    count_q;
  logic               overflow_q;
  logic               irq_en_q;

  logic fifo_empty_c;
  logic fifo_full_c;
  logic push_c;
  logic drop_c;
  logic pop_c;

  assign fifo_empty_c = (count_q == '0);
  assign fifo_full_c  = (count_q == CntW'(Depth));
  // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted
  assign push_c       = wr_data_c && (!fifo_full_c || pop_c);
  assign drop_c       = wr_data_c && fifo_full_c && !pop_c;

  always_ff @(posedge CLK) begin
    if (push_c) begin
      mem[wr_ptr_q] <= BUS_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      irq_en_q   <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      end
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
      if (drop_c) begin
        overflow_q <= 1'b1;
      end else if (wr_ctrl_c && BUS_DATA[0]) begin
        overflow_q <= 1'b0;
      end
      if (wr_ctrl_c) begin
        irq_en_q <= BUS_DATA[1];
      end
    end
  end

  // Transmit FSM
  tx_state_e        state_q;
  tx_state_e        state_d;
  logic [BaudW-1:0] baud_q;
  logic [BaudW-1:0] baud_d;
  logic [2:0]       bit_idx_q;
  logic [2:0]       bit_idx_d;
  logic [7:0]       shreg_q;
  logic [7:0]       shreg_d;
  logic             tx_q;
  logic             tx_d;
  logic             raise_q;
  logic             bit_end_c;
  logic             leave_stop_c;

  assign bit_end_c = (baud_q == BaudLast);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
    end
  end

  // tx_d is the line level for the state being entered, so UART_TX stays registered
  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    tx_d         = 1'b1;
    pop_c        = 1'b0;
    leave_stop_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_c) begin
          pop_c   = 1'b1;
          shreg_d = mem[rd_ptr_q];
          baud_d  = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end_c) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
          tx_d      = shreg_q[0];
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      DATA: begin
        tx_d = shreg_q[0];
        if (bit_end_c) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shreg_d   = {1'b0, shreg_q[7:1]};
            tx_d      = shreg_q[1];
          end
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end_c) begin
          baud_d       = '0;
          state_d      = IDLE;
          leave_stop_c = 1'b1;
        end else begin
          baud_d = baud_q + BaudW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Drain-complete interrupt; a raise on the same edge as ACK takes priority
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      raise_q <= 1'b0;
    end else if (leave_stop_c && fifo_empty_c && irq_en_q) begin
      raise_q <= 1'b1;
    end else if (BUS_INTERRUPT_ACK) begin
      raise_q <= 1'b0;
    end
  end

  // Status read: captured at the addressing edge, driven for one cycle
  status_t    status_c;
  logic       rd_en_q;
  logic [7:0] rd_data_q;

  always_comb begin
    status_c          = '0;
    status_c.full     = fifo_full_c;
    status_c.empty    = fifo_empty_c;
    status_c.busy     = (state_q != IDLE);
    status_c.overflow = overflow_q;
    status_c.count    = 4'(count_q);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_en_q   <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_en_q <= rd_stat_c;
      if (rd_stat_c) begin
        rd_data_q <= status_c;
      end
    end
  end

  assign BUS_DATA            = rd_en_q ? rd_data_q : 8'bz;
  assign UART_TX             = tx_q;
  assign BUS_INTERRUPT_RAISE = raise_q;

endmodule
